// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared types and widths for the data-memory port arbiter.
//   - AW / DW      : address and data width of the single data_mem port.
//   - arb_state_t  : port ownership state (core by default, loader in a burst).
//   - mem_req_t    : one access as presented to data_mem (we, addr, wdata).
// -----------------------------------------------------------------------------
package dmem_pkg;

  localparam int AW = 8;
  localparam int DW = 8;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_LDR  = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/dmem_port_arbiter_starve_counter.sv
// -----------------------------------------------------------------------------
// starve_counter
//   Counts consecutive cycles in which the loader asked for the port and was
//   refused. Saturates at STARVE_MAX; clear has priority over increment.
//   Ports:
//     clk, rst   : clock, asynchronous active-high reset
//     inc        : loader refused this cycle
//     clr        : loader granted or not requesting this cycle
//     cnt        : current count (registered)
//     sat        : cnt == STARVE_MAX, loader must be granted this cycle
// -----------------------------------------------------------------------------
module starve_counter #(
  parameter  int STARVE_MAX = 4,
  localparam int CW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          sat
);

  localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_q;

  // next count: clear wins, otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX_C)) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares the single data_mem port between the core LD/ST path (port 0) and
//   the memory loader/dumper (port 1). The core has priority; a starvation
//   counter forces a loader grant after STARVE_MAX refused cycles, and
//   ldr_lock lets the loader keep the port for a burst.
//   Ports:
//     CLK, reset                       : clock, async active-high reset
//     core_req/we/addr/wdata           : core access request
//     core_gnt, core_stall, core_rvalid: core grant, stall, load data valid
//     ldr_req/lock/we/addr/wdata       : loader access request
//     ldr_gnt, ldr_rvalid              : loader grant, read data valid
//     rdata                            : registered read data (qualify w/ rvalid)
//     mem_addr/rd/wr/wdata, mem_rdata  : data_mem interface
//   AW/DW must match the widths in dmem_pkg (mem_req_t is built from them).
// -----------------------------------------------------------------------------
module dmem_port_arbiter
  import dmem_pkg::*;
#(
  parameter int AW         = dmem_pkg::AW,
  parameter int DW         = dmem_pkg::DW,
  parameter int STARVE_MAX = 4
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_wdata,
  output logic          core_gnt,
  output logic          core_stall,
  output logic          core_rvalid,
  input  logic          ldr_req,
  input  logic          ldr_lock,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_t    state_d, state_q;
  logic          core_rvalid_d, core_rvalid_q;
  logic          ldr_rvalid_d, ldr_rvalid_q;
  logic [DW-1:0] rdata_d, rdata_q;

  logic          core_gnt_c;
  logic          ldr_gnt_c;
  logic          starve_inc;
  logic          starve_clr;
  logic          starve_sat;
  logic [CW-1:0] starve_cnt;
  mem_req_t      sel_req;

  assign starve_inc = ldr_req & ~ldr_gnt_c;
  assign starve_clr = ~starve_inc;

  starve_counter #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk (CLK),
    .rst (reset),
    .inc (starve_inc),
    .clr (starve_clr),
    .cnt (starve_cnt),
    .sat (starve_sat)
  );

  // grant decision and ownership next-state
  always_comb begin
    core_gnt_c = 1'b0;
    ldr_gnt_c  = 1'b0;
    state_d    = state_q;
    // Grants are combinational, so they are masked while reset is high to
    // guarantee no access (in particular no write) reaches data_mem then.
    if (reset) begin
      state_d = OWN_CORE;
    end else begin
      case (state_q)
        OWN_CORE: begin
          if (core_req && !starve_sat) begin
            core_gnt_c = 1'b1;
          end else if (ldr_req) begin
            ldr_gnt_c = 1'b1;
            if (ldr_lock) begin
              state_d = OWN_LDR;
            end else begin
              state_d = OWN_CORE;
            end
          end else begin
            state_d = OWN_CORE;
          end
        end
        OWN_LDR: begin
          // Release takes effect at the edge; the core only becomes eligible
          // in the following cycle.
          if (ldr_req) begin
            ldr_gnt_c = 1'b1;
            if (!ldr_lock) begin
              state_d = OWN_CORE;
            end else begin
              state_d = OWN_LDR;
            end
          end else begin
            state_d = OWN_CORE;
          end
        end
        default: begin
          state_d = OWN_CORE;
        end
      endcase
    end
  end

  // data_mem mux from the granted port; idle port drives zeros
  always_comb begin
    sel_req = '0;
    if (core_gnt_c) begin
      sel_req.we    = core_we;
      sel_req.addr  = core_addr;
      sel_req.wdata = core_wdata;
    end else if (ldr_gnt_c) begin
      sel_req.we    = ldr_we;
      sel_req.addr  = ldr_addr;
      sel_req.wdata = ldr_wdata;
    end else begin
      sel_req = '0;
    end
  end

  // read-return pipeline: capture data and flag the owner for one cycle
  always_comb begin
    core_rvalid_d = core_gnt_c & ~core_we;
    ldr_rvalid_d  = ldr_gnt_c & ~ldr_we;
    if (core_rvalid_d || ldr_rvalid_d) begin
      rdata_d = mem_rdata;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // state and read-return registers
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q       <= OWN_CORE;
      core_rvalid_q <= 1'b0;
      ldr_rvalid_q  <= 1'b0;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      core_rvalid_q <= core_rvalid_d;
      ldr_rvalid_q  <= ldr_rvalid_d;
      rdata_q       <= rdata_d;
    end
  end

  assign core_gnt    = core_gnt_c;
  assign ldr_gnt     = ldr_gnt_c;
  assign core_stall  = core_req & ~core_gnt_c;
  assign core_rvalid = core_rvalid_q;
  assign ldr_rvalid  = ldr_rvalid_q;
  assign rdata       = rdata_q;
  assign mem_addr    = sel_req.addr;
  assign mem_wdata   = sel_req.wdata;
  assign mem_rd      = (core_gnt_c | ldr_gnt_c) & ~sel_req.we;
  assign mem_wr      = (core_gnt_c | ldr_gnt_c) & sel_req.we;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
//   Directed, table-driven bench for dmem_port_arbiter with a behavioural
//   256x8 data_mem (combinational read, write at the clock edge).
//   Each table row gives one cycle of inputs and the outputs expected in that
//   cycle; rvalid/rdata columns describe the previous row's grant.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

  logic       clk;
  logic       reset;
  logic       core_req, core_we;
  logic [7:0] core_addr, core_wdata;
  logic       core_gnt, core_stall, core_rvalid;
  logic       ldr_req, ldr_lock, ldr_we;
  logic [7:0] ldr_addr, ldr_wdata;
  logic       ldr_gnt, ldr_rvalid;
  logic [7:0] rdata;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       mem_rd, mem_wr;

  logic [7:0] mem [256];

  int n_total;
  int n_pass;

  dmem_port_arbiter #(.AW(8), .DW(8), .STARVE_MAX(4)) dut (
    .CLK        (clk),
    .reset      (reset),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_gnt   (core_gnt),
    .core_stall (core_stall),
    .core_rvalid(core_rvalid),
    .ldr_req    (ldr_req),
    .ldr_lock   (ldr_lock),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_gnt    (ldr_gnt),
    .ldr_rvalid (ldr_rvalid),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  typedef struct {
    logic       cr, cw;
    logic [7:0] ca, cd;
    logic       lr, lk, lw;
    logic [7:0] la, ld;
    logic       cg, cs, lg, mrd, mwr;
    logic [7:0] ma, mwd;
    logic       crv, lrv;
    logic [7:0] rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic cr, cw, input logic [7:0] ca, cd,
    input logic lr, lk, lw, input logic [7:0] la, ld,
    input logic cg, cs, lg, mrd, mwr, input logic [7:0] ma, mwd,
    input logic crv, lrv, input logic [7:0] rd);
    vec_t v;
    v.cr = cr;  v.cw = cw;  v.ca = ca;  v.cd = cd;
    v.lr = lr;  v.lk = lk;  v.lw = lw;  v.la = la;  v.ld = ld;
    v.cg = cg;  v.cs = cs;  v.lg = lg;  v.mrd = mrd; v.mwr = mwr;
    v.ma = ma;  v.mwd = mwd; v.crv = crv; v.lrv = lrv; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] got, input logic [7:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s [step %0d]: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  task automatic drive_idle();
    core_req = 1'b0; core_we = 1'b0; core_addr = 8'h00; core_wdata = 8'h00;
    ldr_req = 1'b0; ldr_lock = 1'b0; ldr_we = 1'b0; ldr_addr = 8'h00; ldr_wdata = 8'h00;
  endtask

  // Drive one row just after the rising edge, check it at the falling edge.
  task automatic apply(input vec_t v, input int idx);
    core_req = v.cr; core_we = v.cw; core_addr = v.ca; core_wdata = v.cd;
    ldr_req = v.lr; ldr_lock = v.lk; ldr_we = v.lw; ldr_addr = v.la; ldr_wdata = v.ld;
    @(negedge clk);
    chk("core_gnt",    idx, {7'd0, core_gnt},    {7'd0, v.cg});
    chk("core_stall",  idx, {7'd0, core_stall},  {7'd0, v.cs});
    chk("ldr_gnt",     idx, {7'd0, ldr_gnt},     {7'd0, v.lg});
    chk("mem_rd",      idx, {7'd0, mem_rd},      {7'd0, v.mrd});
    chk("mem_wr",      idx, {7'd0, mem_wr},      {7'd0, v.mwr});
    chk("mem_addr",    idx, mem_addr,            v.ma);
    chk("mem_wdata",   idx, mem_wdata,           v.mwd);
    chk("core_rvalid", idx, {7'd0, core_rvalid}, {7'd0, v.crv});
    chk("ldr_rvalid",  idx, {7'd0, ldr_rvalid},  {7'd0, v.lrv});
    if (v.crv || v.lrv) chk("rdata", idx, rdata, v.rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;
    mem[8'h20] = 8'h77;
    mem[8'h00] = 8'hEE; mem[8'h01] = 8'hEE; mem[8'h02] = 8'hEE; mem[8'h03] = 8'hEE;
    mem[8'hFF] = 8'h11;
    mem[8'h40] = 8'h55; mem[8'h41] = 8'h66; mem[8'h42] = 8'h99;

    // --- idle / core read 0x10 ---
    vecs.push_back(mk(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,0,8'h00,8'h00, 0,0,8'h00));
    vecs.push_back(mk(1,0,8'h10,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,1,0,8'h10,8'h00, 0,0,8'h00));
    vecs.push_back(mk(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,0,8'h00,8'h00, 1,0,8'h5A));
    vecs.push_back(mk(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,0,8'h00,8'h00, 0,0,8'h00));
    // --- starvation: core wins 4 cycles, ldr forced on the 5th ---
    vecs.push_back(mk(1,0,8'h20,8'h00, 1,0,0,8'h02,8'h00, 1,0,0,1,0,8'h20,8'h00, 0,0,8'h00));
    vecs.push_back(mk(1,0,8'h20,8'h00, 1,0,0,8'h02,8'h00, 1,0,0,1,0,8'h20,8'h00, 1,0,8'h77));
    vecs.push_back(mk(1,0,8'h20,8'h00, 1,0,0,8'h02,8'h00, 1,0,0,1,0,8'h20,8'h00, 1,0,8'h77));
    vecs.push_back(mk(1,0,8'h20,8'h00, 1,0,0,8'h02,8'h00, 1,0,0,1,0,8'h20,8'h00, 1,0,8'h77));
    vecs.push_back(mk(1,0,8'h20,8'h00, 1,0,0,8'h02,8'h00, 0,1,1,1,0,8'h02,8'h00, 1,0,8'h77));
    vecs.push_back(mk(1,0,8'h20,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,1,0,8'h20,8'h00, 0,1,8'hEE));
    vecs.push_back(mk(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,0,8'h00,8'h00, 1,0,8'h77));
    // --- locked ldr burst writes 00..03 with core_req held ---
    vecs.push_back(mk(1,0,8'h03,8'h00, 1,1,1,8'h00,8'h00, 1,0,0,1,0,8'h03,8'h00, 0,0,8'h00));
    vecs.push_back(mk(1,0,8'h03,8'h00, 1,1,1,8'h00,8'h00, 1,0,0,1,0,8'h03,8'h00, 1,0,8'hEE));
    vecs.push_back(mk(1,0,8'h03,8'h00, 1,1,1,8'h00,8'h00, 1,0,0,1,0,8'h03,8'h00, 1,0,8'hEE));
    vecs.push_back(mk(1,0,8'h03,8'h00, 1,1,1,8'h00,8'h00, 1,0,0,1,0,8'h03,8'h00, 1,0,8'hEE));
    vecs.push_back(mk(1,0,8'h03,8'h00, 1,1,1,8'h00,8'h00, 0,1,1,0,1,8'h00,8'h00, 1,0,8'hEE));
    vecs.push_back(mk(1,0,8'h03,8'h00, 1,1,1,8'h01,8'h01, 0,1,1,0,1,8'h01,8'h01, 0,0,8'h00));
    vecs.push_back(mk(1,0,8'h03,8'h00, 1,1,1,8'h02,8'h02, 0,1,1,0,1,8'h02,8'h02, 0,0,8'h00));
    vecs.push_back(mk(1,0,8'h03,8'h00, 1,0,1,8'h03,8'h03, 0,1,1,0,1,8'h03,8'h03, 0,0,8'h00));
    // --- core readback of the burst ---
    vecs.push_back(mk(1,0,8'h03,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,1,0,8'h03,8'h00, 0,0,8'h00));
    vecs.push_back(mk(1,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,1,0,8'h00,8'h00, 1,0,8'h03));
    vecs.push_back(mk(1,0,8'h01,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,1,0,8'h01,8'h00, 1,0,8'h00));
    vecs.push_back(mk(1,0,8'h02,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,1,0,8'h02,8'h00, 1,0,8'h01));
    vecs.push_back(mk(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,0,8'h00,8'h00, 1,0,8'h02));
    // --- ldr read 0xFF vs simultaneous core store ---
    vecs.push_back(mk(1,1,8'hFF,8'hC3, 1,0,0,8'hFF,8'h00, 1,0,0,0,1,8'hFF,8'hC3, 0,0,8'h00));
    vecs.push_back(mk(0,0,8'h00,8'h00, 1,0,0,8'hFF,8'h00, 0,0,1,1,0,8'hFF,8'h00, 0,0,8'h00));
    vecs.push_back(mk(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,0,8'h00,8'h00, 0,1,8'hC3));
    vecs.push_back(mk(0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,0,0,8'h00,8'h00, 0,0,8'h00));

    // --- reset held: grants masked even with both requests up ---
    reset = 1'b1;
    drive_idle();
    core_req = 1'b1; ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h30; ldr_wdata = 8'hAB;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_core_gnt",    0, {7'd0, core_gnt},    8'h00);
    chk("rst_ldr_gnt",     0, {7'd0, ldr_gnt},     8'h00);
    chk("rst_mem_wr",      0, {7'd0, mem_wr},      8'h00);
    chk("rst_mem_rd",      0, {7'd0, mem_rd},      8'h00);
    chk("rst_mem_addr",    0, mem_addr,            8'h00);
    chk("rst_core_rvalid", 0, {7'd0, core_rvalid}, 8'h00);
    chk("rst_ldr_rvalid",  0, {7'd0, ldr_rvalid},  8'h00);
    chk("rst_rdata",       0, rdata,               8'h00);
    drive_idle();
    @(negedge clk);
    chk("rst_core_stall",  0, {7'd0, core_stall},  8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i + 1);

    // --- reset asserted mid-cycle during a locked burst ---
    ldr_req = 1'b1; ldr_lock = 1'b1; ldr_we = 1'b1; ldr_addr = 8'h40; ldr_wdata = 8'hAA;
    @(negedge clk);
    chk("mrst_a_ldr_gnt", 100, {7'd0, ldr_gnt}, 8'h01);
    chk("mrst_a_mem_wr",  100, {7'd0, mem_wr},  8'h01);
    @(posedge clk); #1;
    ldr_we = 1'b0; ldr_addr = 8'h42; ldr_wdata = 8'h00;
    @(negedge clk);
    chk("mrst_b_mem_rd",  101, {7'd0, mem_rd},  8'h01);
    @(posedge clk); #1;
    ldr_we = 1'b1; ldr_addr = 8'h41; ldr_wdata = 8'hBB;
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h41;
    @(negedge clk);
    chk("mrst_c_ldr_gnt",    102, {7'd0, ldr_gnt},    8'h01);
    chk("mrst_c_core_gnt",   102, {7'd0, core_gnt},   8'h00);
    chk("mrst_c_ldr_rvalid", 102, {7'd0, ldr_rvalid}, 8'h01);
    chk("mrst_c_rdata",      102, rdata,              8'h99);
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_r_ldr_gnt",    103, {7'd0, ldr_gnt},    8'h00);
    chk("mrst_r_mem_wr",     103, {7'd0, mem_wr},     8'h00);
    chk("mrst_r_core_gnt",   103, {7'd0, core_gnt},   8'h00);
    chk("mrst_r_ldr_rvalid", 103, {7'd0, ldr_rvalid}, 8'h00);
    chk("mrst_r_rdata",      103, rdata,              8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    // Back in OWN_CORE: the core wins although the loader still requests.
    @(negedge clk);
    chk("mrst_d_core_gnt", 104, {7'd0, core_gnt}, 8'h01);
    chk("mrst_d_ldr_gnt",  104, {7'd0, ldr_gnt},  8'h00);
    chk("mrst_d_mem_addr", 104, mem_addr,         8'h41);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    chk("mrst_e_core_rvalid", 105, {7'd0, core_rvalid}, 8'h01);
    chk("mrst_e_rdata",       105, rdata,               8'h66);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
